// File: rtl/mem_io_responder_if.sv
// Initiator/responder memory bus: byte address, read strobe, byte-lane write mask.
interface mem_io_responder_if;
  logic [31:0] addr;
  logic        rstrb;
  logic [31:0] rdata;
  logic [3:0]  wmask;
  logic [31:0] wdata;

  modport master (output addr, rstrb, wmask, wdata, input rdata);
  modport slave  (input addr, rstrb, wmask, wdata, output rdata);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-bus responder: word RAM plus an IO page with LED register and UART 8N1 TX.
// Define MEM_IO_RESPONDER_TX_FIFO_EN to put a 4-entry byte FIFO in front of the TX shifter.
module mem_io_responder #(
  parameter int unsigned MEM_WORDS_LOG2 = 11,
  parameter string       INIT_FILE      = "firmware.hex",
  parameter int unsigned CLK_FREQ_HZ    = 12000000,
  parameter int unsigned BAUD_RATE      = 115200
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_io_responder_if.slave   bus,
  output logic [4:0]          leds_o,
  output logic                uart_tx_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MEM_WORDS    = 2 ** MEM_WORDS_LOG2;

  localparam logic [2:0] OFF_LEDS   = 3'd0;
  localparam logic [2:0] OFF_UDATA  = 3'd1;
  localparam logic [2:0] OFF_USTAT  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  logic [31:0]               ram [MEM_WORDS];
  logic [MEM_WORDS_LOG2-1:0] ram_idx_c;
  logic [2:0]                io_off_c;
  logic                      sel_io_c;
  logic                      wr_c;
  logic                      push_c;
  logic [31:0]               io_rdata_c;

  tx_state_t                 state;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [2:0]                bit_cnt;
  logic [7:0]                shifter;
  logic                      bit_end_c;
  logic                      frame_done_c;
  logic                      tx_busy_c;
  logic                      tx_full_c;
  logic                      load_c;
  logic [7:0]                load_byte_c;

  assign sel_io_c  = bus.addr[22];
  assign ram_idx_c = bus.addr[MEM_WORDS_LOG2+1:2];
  assign io_off_c  = bus.addr[4:2];
  assign wr_c      = |bus.wmask;
  assign push_c    = wr_c && sel_io_c && (io_off_c == OFF_UDATA) && bus.wmask[0];

  wire unused_addr_c = &{1'b0, bus.addr[31:23], bus.addr[21:MEM_WORDS_LOG2+2], bus.addr[1:0]};

  always_ff @(posedge clk_i) begin
    if (wr_c && !sel_io_c) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.wmask[k]) ram[ram_idx_c][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    io_rdata_c = '0;
    case (io_off_c)
      OFF_LEDS:  io_rdata_c = {27'b0, leds_o};
      OFF_USTAT: io_rdata_c = {30'b0, tx_full_c, tx_busy_c};
      default:   io_rdata_c = '0;
    endcase
  end

  // Single-cycle read; a same-cycle write to the word is seen on the next read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rdata <= '0;
    end else if (bus.rstrb) begin
      bus.rdata <= sel_io_c ? io_rdata_c : ram[ram_idx_c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      leds_o <= '0;
    end else if (wr_c && sel_io_c && (io_off_c == OFF_LEDS) && bus.wmask[0]) begin
      leds_o <= bus.wdata[4:0];
    end
  end

  assign bit_end_c    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_done_c = (state == ST_STOP) && bit_end_c;

`ifdef MEM_IO_RESPONDER_TX_FIFO_EN
  // The head entry stays queued while it is on the wire and is popped when its stop bit ends.
  logic [7:0] fifo_q [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [1:0] rd_nxt_c;
  logic [2:0] count;
  logic       pop_c;
  logic       push_ok_c;

  assign rd_nxt_c    = rd_ptr + 2'd1;
  assign tx_full_c   = (count == 3'd4);
  assign tx_busy_c   = (state != ST_IDLE) || (count != 3'd0);
  assign pop_c       = frame_done_c;
  assign push_ok_c   = push_c && (!tx_full_c || pop_c);
  assign load_c      = ((state == ST_IDLE) && (count != 3'd0)) ||
                       (frame_done_c && ((count > 3'd1) || ((count == 3'd1) && push_ok_c)));
  assign load_byte_c = (state == ST_IDLE) ? fifo_q[rd_ptr] :
                       (count > 3'd1)     ? fifo_q[rd_nxt_c] : bus.wdata[7:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) begin
        fifo_q[wr_ptr] <= bus.wdata[7:0];
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop_c) rd_ptr <= rd_nxt_c;
      count <= count + 3'(push_ok_c) - 3'(pop_c);
    end
  end
`else
  assign tx_busy_c   = (state != ST_IDLE);
  assign tx_full_c   = tx_busy_c;
  assign load_c      = push_c && (state == ST_IDLE);
  assign load_byte_c = bus.wdata[7:0];
`endif

  // TX framer: start, 8 data bits LSB first, stop; each bit CLKS_PER_BIT cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      uart_tx_o <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (load_c) begin
            shifter   <= load_byte_c;
            state     <= ST_START;
            uart_tx_o <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_c) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= ST_DATA;
            uart_tx_o <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state     <= ST_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shifter   <= {1'b0, shifter[7:1]};
              uart_tx_o <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (load_c) begin
              shifter   <= load_byte_c;
              state     <= ST_START;
              uart_tx_o <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM/IO vector table plus UART frame, burst and reset sequences.
module tb_mem_io_responder;
  localparam int unsigned CPB = 4;
  localparam logic [31:0] A_LEDS  = 32'h0040_0000;
  localparam logic [31:0] A_UDATA = 32'h0040_0004;
  localparam logic [31:0] A_USTAT = 32'h0040_0008;
`ifdef MEM_IO_RESPONDER_TX_FIFO_EN
  localparam logic [31:0] STAT_MID = 32'd1;
  localparam int          LAT      = 1;
  localparam int          BURST_N  = 4;
`else
  localparam logic [31:0] STAT_MID = 32'd3;
  localparam int          LAT      = 0;
  localparam int          BURST_N  = 1;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic [4:0] leds;
  logic uart_tx;
  int checks = 0;
  int errors = 0;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .MEM_WORDS_LOG2(8), .INIT_FILE(""), .CLK_FREQ_HZ(16), .BAUD_RATE(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus.slave), .leds_o(leds), .uart_tx_o(uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  vec_t vecs[20];

  // UART receive monitor: records start cycle and byte of every frame seen on uart_tx.
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_ph = 0;
  int         mon_st = 0;
  int         mon_cnt = 0;
  int         mon_bad_stop = 0;
  logic [7:0] mon_sh;
  logic [7:0] mon_bytes[16];
  int         mon_start[16];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (uart_tx == 1'b0) begin
          mon_act = 1'b1;
          mon_ph  = 0;
          mon_sh  = '0;
          mon_st  = cyc;
        end
      end else begin
        mon_ph++;
        if ((mon_ph % CPB) == CPB / 2) begin
          if (mon_ph / CPB >= 1 && mon_ph / CPB <= 8) begin
            mon_sh[mon_ph / CPB - 1] = uart_tx;
          end else if (mon_ph / CPB == 9) begin
            if (uart_tx !== 1'b1) mon_bad_stop++;
            if (mon_cnt < 16) begin
              mon_bytes[mon_cnt] = mon_sh;
              mon_start[mon_cnt] = mon_st;
            end
            mon_cnt++;
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.rstrb = 1'b0;
    bus.wmask = 4'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.addr  = a;
    bus.wdata = d;
    bus.wmask = m;
    bus.rstrb = 1'b0;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.wmask = 4'b0;
    bus.rstrb = 1'b1;
    @(posedge clk); #1;
    bus.rstrb = 1'b0;
    d = bus.rdata;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    logic [7:0] t;
    t = b;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return t[i-1];
  endfunction

  initial begin
    logic [31:0] rd;
    int          low_cnt;

    vecs[0]  = '{32'h10,     32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,        5'h00};
    vecs[1]  = '{32'h11,     32'h0000_5500, 4'h2, 1'b0, 1'b0, 32'h0,       5'h00};
    vecs[2]  = '{32'h10,     32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD55EF, 5'h00};
    vecs[3]  = '{32'h10,     32'h0,        4'h0, 1'b0, 1'b1, 32'hDEAD55EF, 5'h00};
    vecs[4]  = '{32'h20,     32'h11111111, 4'hF, 1'b0, 1'b1, 32'hDEAD55EF, 5'h00};
    vecs[5]  = '{32'h20,     32'h22222222, 4'hF, 1'b1, 1'b1, 32'h11111111, 5'h00};
    vecs[6]  = '{32'h20,     32'h0,        4'h0, 1'b1, 1'b1, 32'h22222222, 5'h00};
    vecs[7]  = '{32'h420,    32'h0,        4'h0, 1'b1, 1'b1, 32'h22222222, 5'h00};
    vecs[8]  = '{32'h10,     32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD55EF, 5'h00};
    vecs[9]  = '{A_LEDS,     32'h0000000A, 4'h1, 1'b0, 1'b0, 32'h0,        5'h0A};
    vecs[10] = '{A_LEDS,     32'h0,        4'h0, 1'b1, 1'b1, 32'h0000000A, 5'h0A};
    vecs[11] = '{A_LEDS,     32'h00001F1F, 4'h2, 1'b0, 1'b0, 32'h0,        5'h0A};
    vecs[12] = '{A_UDATA,    32'h0,        4'h0, 1'b1, 1'b1, 32'h0,        5'h0A};
    vecs[13] = '{A_USTAT,    32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 32'h0,        5'h0A};
    vecs[14] = '{A_USTAT,    32'h0,        4'h0, 1'b1, 1'b1, 32'h0,        5'h0A};
    vecs[15] = '{32'h40000C, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0,        5'h0A};
    vecs[16] = '{32'h40001C, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0,        5'h0A};
    vecs[17] = '{A_LEDS,     32'h0,        4'h0, 1'b1, 1'b1, 32'h0000000A, 5'h0A};
    vecs[18] = '{32'h400010, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0,        5'h0A};
    vecs[19] = '{32'h10,     32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD55EF, 5'h0A};

    // Reset state
    bus.addr = '0; bus.wdata = '0;
    bus_idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_tx", 32'(uart_tx), 32'h1);
    bus_read(A_USTAT, rd);
    check("reset_status", rd, 32'h0);

    // RAM and IO decode vectors
    for (int i = 0; i < 20; i++) begin
      bus.addr  = vecs[i].addr;
      bus.wdata = vecs[i].wdata;
      bus.wmask = vecs[i].wmask;
      bus.rstrb = vecs[i].rstrb;
      @(posedge clk); #1;
      bus_idle();
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    // Single frame of 0xA5, status read in the middle of it
    check("pre_frame_tx", 32'(uart_tx), 32'h1);
    bus_write(A_UDATA, 32'hA5, 4'h1);
    repeat (LAT) begin @(posedge clk); #1; end
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      check($sformatf("frame_a5_c%0d", i), 32'(uart_tx), 32'(frame_bit(8'hA5, i / CPB)));
      if (i == 10) begin
        bus.addr  = A_USTAT;
        bus.rstrb = 1'b1;
      end
      if (i == 11) begin
        bus.rstrb = 1'b0;
        check("status_mid_frame", bus.rdata, STAT_MID);
      end
    end
    @(posedge clk); #1;
    bus_read(A_USTAT, rd);
    check("status_after_frame", rd, 32'h0);
    check("tx_after_frame", 32'(uart_tx), 32'h1);

    // Back-to-back pushes 0x01..0x05
    mon_cnt = 0;
    mon_bad_stop = 0;
    mon_en = 1'b1;
    for (int b = 1; b <= 5; b++) bus_write(A_UDATA, 32'(b), 4'h1);
    bus_read(A_USTAT, rd);
    check("status_burst_full", rd, 32'h3);
    repeat (200) @(posedge clk);
    #1;
    check("burst_frame_count", 32'(mon_cnt), 32'(BURST_N));
    check("burst_stop_bits", 32'(mon_bad_stop), 32'h0);
    for (int k = 0; k < BURST_N && k < mon_cnt; k++) begin
      check($sformatf("burst_byte%0d", k), 32'(mon_bytes[k]), 32'(k + 1));
      if (k > 0) check($sformatf("burst_gap%0d", k), 32'(mon_start[k] - mon_start[k-1]), 32'(10 * CPB));
    end
    bus_read(A_USTAT, rd);
    check("status_after_burst", rd, 32'h0);

    // Reset in the middle of a frame with a second byte pending
    mon_en = 1'b0;
    bus_read(32'h10, rd);
    check("pre_reset_rdata", rd, 32'hDEAD55EF);
    bus_write(A_UDATA, 32'h3C, 4'h1);
    bus_write(A_UDATA, 32'h5A, 4'h1);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_tx_low", 32'(uart_tx), 32'h0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mid_reset_tx", 32'(uart_tx), 32'h1);
    check("mid_reset_rdata", bus.rdata, 32'h0);
    check("mid_reset_leds", 32'(leds), 32'h0);
    mon_cnt = 0;
    mon_en  = 1'b1;
    bus_read(A_USTAT, rd);
    check("mid_reset_status", rd, 32'h0);
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("post_reset_tx_quiet", 32'(low_cnt), 32'h0);
    check("post_reset_frames", 32'(mon_cnt), 32'h0);
    @(posedge clk); #1;
    bus_write(A_LEDS, 32'h1F, 4'h1);
    check("leds_after_reset", 32'(leds), 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
